// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a single-port read-first RAM with 2-cycle read latency.
// Define RAM_ARB_FIXED_PRIO_EN for fixed B-over-A priority instead of round-robin.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              reloj,
  input  logic              reset,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dataIn,
  output logic              ram_we,
  output logic              ram_enable,
  output logic              ram_re,
  output logic              ram_reset,
  input  logic [DATA_W-1:0] ram_dataOut
);

  // Read tag pipeline: id 0 = port A, 1 = port B.
  logic s0_valid_q, s0_valid_d;
  logic s0_id_q, s0_id_d;
  logic s1_valid_q;
  logic s1_id_q;

`ifndef RAM_ARB_FIXED_PRIO_EN
  logic last_gnt_q, last_gnt_d;
`endif

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!reset) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
      b_gnt = b_req;
      a_gnt = a_req & ~b_req;
`else
      if (a_req && b_req) begin
        // The port that did not win last time takes the conflict.
        if (last_gnt_q) begin
          a_gnt = 1'b1;
        end else begin
          b_gnt = 1'b1;
        end
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
`endif
    end
  end

  always_comb begin
    ram_enable = a_gnt | b_gnt;
    ram_we     = b_gnt & b_we;
    ram_dataIn = b_wdata;
    ram_addr   = '0;
    if (b_gnt) begin
      ram_addr = b_addr;
    end else if (a_gnt) begin
      ram_addr = a_addr;
    end
  end

  always_comb begin
    // Writes never enter the tag pipeline, so they produce no return.
    s0_valid_d = a_gnt | (b_gnt & ~b_we);
    s0_id_d    = b_gnt;
`ifndef RAM_ARB_FIXED_PRIO_EN
    last_gnt_d = last_gnt_q;
    if (a_gnt || b_gnt) begin
      last_gnt_d = b_gnt;
    end
`endif
  end

  always_ff @(posedge reloj) begin
    if (reset) begin
      s0_valid_q <= 1'b0;
      s0_id_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_id_q    <= 1'b0;
    end else begin
      s0_valid_q <= s0_valid_d;
      s0_id_q    <= s0_id_d;
      s1_valid_q <= s0_valid_q;
      s1_id_q    <= s0_id_q;
    end
  end

`ifndef RAM_ARB_FIXED_PRIO_EN
  always_ff @(posedge reloj) begin
    if (reset) begin
      last_gnt_q <= 1'b0;
    end else begin
      last_gnt_q <= last_gnt_d;
    end
  end
`endif

  // RAM output register only loads when a real read sits in stage 0.
  assign ram_re    = s0_valid_q;
  assign ram_reset = reset;

  assign a_rvalid = s1_valid_q & ~s1_id_q;
  assign b_rvalid = s1_valid_q & s1_id_q;
  assign a_rdata  = ram_dataOut;
  assign b_rdata  = ram_dataOut;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a read-first, 2-cycle-latency RAM model.
// Returns are checked by a scoreboard of expected {port, data, due cycle}.
module tb_ram_port_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic          reloj = 1'b0;
  logic          reset;
  logic          a_req, a_gnt, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_rdata;
  logic          b_req, b_we, b_gnt, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dataIn, ram_dataOut;
  logic          ram_we, ram_enable, ram_re, ram_reset;

  ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .reloj      (reloj),
    .reset      (reset),
    .a_req      (a_req),
    .a_addr     (a_addr),
    .a_gnt      (a_gnt),
    .a_rvalid   (a_rvalid),
    .a_rdata    (a_rdata),
    .b_req      (b_req),
    .b_we       (b_we),
    .b_addr     (b_addr),
    .b_wdata    (b_wdata),
    .b_gnt      (b_gnt),
    .b_rvalid   (b_rvalid),
    .b_rdata    (b_rdata),
    .ram_addr   (ram_addr),
    .ram_dataIn (ram_dataIn),
    .ram_we     (ram_we),
    .ram_enable (ram_enable),
    .ram_re     (ram_re),
    .ram_reset  (ram_reset),
    .ram_dataOut(ram_dataOut)
  );

  always #5 reloj = ~reloj;

  function automatic logic [DW-1:0] init_val(input int i);
    logic [DW-1:0] v;
    v = i;
    if (i == 3) return 32'h0000_00A5;
    return 32'h5A00_0000 + v * 32'h0001_0011;
  endfunction

  // RAM model: read-first latch at the access edge, output register loaded by re.
  logic [DW-1:0] ram_mem [16];
  logic [DW-1:0] ram_lat;
  logic          ram_init_done = 1'b0;

  always @(posedge reloj) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= init_val(i);
      ram_init_done <= 1'b1;
    end else if (ram_enable) begin
      ram_lat <= ram_mem[ram_addr];
      if (ram_we) ram_mem[ram_addr] <= ram_dataIn;
    end
    if (ram_reset) ram_dataOut <= '0;
    else if (ram_re) ram_dataOut <= ram_lat;
  end

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
    int            due;
  } ent_t;

  ent_t          sb[$];
  logic [DW-1:0] exp_mem [16];
  int            errors = 0;
  int            checks = 0;
  int            cyc = 0;
  logic          mon_en = 1'b0;

  task automatic run_scoreboard();
    ent_t          e;
    logic          exp_a, exp_b;
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 16; i++) exp_mem[i] = init_val(i);
    forever begin
      @(negedge reloj);
      cyc++;
      if (mon_en) begin
        exp_a = 1'b0;
        exp_b = 1'b0;
        exp_d = '0;
        if (sb.size() != 0 && sb[0].due == cyc) begin
          e = sb.pop_front();
          if (e.port) exp_b = 1'b1;
          else exp_a = 1'b1;
          exp_d = e.data;
        end
        checks++;
        if (a_rvalid !== exp_a) begin
          errors++;
          $display("FAIL sb_a_rvalid cyc %0d: got %b want %b", cyc, a_rvalid, exp_a);
        end
        checks++;
        if (b_rvalid !== exp_b) begin
          errors++;
          $display("FAIL sb_b_rvalid cyc %0d: got %b want %b", cyc, b_rvalid, exp_b);
        end
        if (exp_a) begin
          checks++;
          if (a_rdata !== exp_d) begin
            errors++;
            $display("FAIL sb_a_rdata cyc %0d: got %h want %h", cyc, a_rdata, exp_d);
          end
        end
        if (exp_b) begin
          checks++;
          if (b_rdata !== exp_d) begin
            errors++;
            $display("FAIL sb_b_rdata cyc %0d: got %h want %h", cyc, b_rdata, exp_d);
          end
        end
        checks++;
        if ((a_gnt & b_gnt) !== 1'b0) begin
          errors++;
          $display("FAIL sb_one_gnt cyc %0d: got a=%b b=%b want at most one", cyc, a_gnt, b_gnt);
        end
        if (reset) begin
          sb.delete();
        end else begin
          if (a_req && a_gnt) sb.push_back('{1'b0, exp_mem[a_addr], cyc + 2});
          if (b_req && b_gnt) begin
            if (b_we) exp_mem[b_addr] = b_wdata;
            else sb.push_back('{1'b1, exp_mem[b_addr], cyc + 2});
          end
        end
      end
    end
  endtask

  task automatic drive(input logic rst, input logic ar, input logic [AW-1:0] aa,
                       input logic br, input logic bw, input logic [AW-1:0] ba,
                       input logic [DW-1:0] bd);
    @(posedge reloj);
    #1;
    reset = rst;  a_req = ar;  a_addr = aa;
    b_req = br;   b_we = bw;   b_addr = ba;  b_wdata = bd;
    @(negedge reloj);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge reloj);
      #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending returns want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 4'd5, 32'hFFFF_FFFF);
    mon_en = 1'b1;
    checks++;
    if ({a_gnt, b_gnt, ram_enable, ram_we} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_ctrl: got a_gnt,b_gnt,en,we=%b want 0000", {a_gnt, b_gnt, ram_enable, ram_we});
    end
    checks++;
    if ({ram_reset, a_rvalid, b_rvalid} !== 3'b100) begin
      errors++;
      $display("FAIL rst_out: got ram_reset,a_rv,b_rv=%b want 100", {ram_reset, a_rvalid, b_rvalid});
    end
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'h0);
    checks++;
    if ({ram_reset, ram_enable, ram_re} !== 3'b000) begin
      errors++;
      $display("FAIL rst_idle: got ram_reset,en,re=%b want 000", {ram_reset, ram_enable, ram_re});
    end
  endtask

  task automatic test_single_read();
    drive(1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 32'h0);
    checks++;
    if ({a_gnt, b_gnt, ram_enable, ram_we} !== 4'b1010) begin
      errors++;
      $display("FAIL rd_gnt: got a_gnt,b_gnt,en,we=%b want 1010", {a_gnt, b_gnt, ram_enable, ram_we});
    end
    checks++;
    if (ram_addr !== 4'd3) begin
      errors++;
      $display("FAIL rd_addr: got %0d want 3", ram_addr);
    end
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'h0);
    checks++;
    if ({ram_re, ram_enable} !== 2'b10) begin
      errors++;
      $display("FAIL rd_re: got re,en=%b want 10", {ram_re, ram_enable});
    end
    drain();
  endtask

  task automatic test_write_read();
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd5, 32'hDEAD_BEEF);
    checks++;
    if ({b_gnt, a_gnt, ram_we, ram_enable} !== 4'b1011) begin
      errors++;
      $display("FAIL wr_ctrl: got b_gnt,a_gnt,we,en=%b want 1011", {b_gnt, a_gnt, ram_we, ram_enable});
    end
    checks++;
    if ({ram_addr, ram_dataIn} !== {4'd5, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL wr_bus: got addr %0d data %h want 5 deadbeef", ram_addr, ram_dataIn);
    end
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 32'h0);
    checks++;
    if ({b_gnt, ram_we, ram_re} !== 3'b100) begin
      errors++;
      $display("FAIL wr_then_rd: got b_gnt,we,re=%b want 100", {b_gnt, ram_we, ram_re});
    end
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'h0);
    checks++;
    if (ram_re !== 1'b1) begin
      errors++;
      $display("FAIL wr_rd_re: got %b want 1", ram_re);
    end
    drain();
  endtask

  task automatic test_conflict();
    logic [4:0] want_b;
`ifdef RAM_ARB_FIXED_PRIO_EN
    want_b = 5'b01111;
`else
    want_b = 5'b00101;
`endif
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, 4'd1, (k < 4), 1'b0, 4'd2, 32'h0);
      checks++;
      if ({b_gnt, a_gnt} !== {want_b[k], ~want_b[k]}) begin
        errors++;
        $display("FAIL arb_%0d: got b_gnt,a_gnt=%b%b want %b%b", k, b_gnt, a_gnt, want_b[k],
                 ~want_b[k]);
      end
      checks++;
      if (ram_addr !== (want_b[k] ? 4'd2 : 4'd1)) begin
        errors++;
        $display("FAIL arb_addr_%0d: got %0d want %0d", k, ram_addr, want_b[k] ? 2 : 1);
      end
    end
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'h0);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] ad;
    for (int i = 0; i < 8; i++) begin
      ad = AW'(i);
      drive(1'b0, 1'b1, ad, 1'b0, 1'b0, 4'd0, 32'h0);
      checks++;
      if ({a_gnt, ram_addr} !== {1'b1, ad}) begin
        errors++;
        $display("FAIL b2b_%0d: got gnt %b addr %0d want 1 %0d", i, a_gnt, ram_addr, ad);
      end
    end
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'h0);
    drain();
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 4'd0, 32'h0);
    checks++;
    if (a_gnt !== 1'b1) begin
      errors++;
      $display("FAIL mid_gnt: got %b want 1", a_gnt);
    end
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'h0);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 32'h0);
    checks++;
    if ({b_gnt, a_rvalid, b_rvalid} !== 3'b100) begin
      errors++;
      $display("FAIL mid_after: got b_gnt,a_rv,b_rv=%b want 100", {b_gnt, a_rvalid, b_rvalid});
    end
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 32'h0);
    drain();
  endtask

  initial begin
    reset = 1'b1;  a_req = 1'b0;  a_addr = '0;
    b_req = 1'b0;  b_we = 1'b0;   b_addr = '0;  b_wdata = '0;
    fork
      run_scoreboard();
    join_none
    test_reset();
    test_single_read();
    test_write_read();
    test_conflict();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge reloj);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
